// File: rtl/u_imem.sv
// u_imem -- instruction memory with a byte-stream boot loader.
//
// Purpose:
//   Holds 2^AW 32-bit instruction words. A boot load, started by a pulse on
//   ld_start, assembles a little-endian byte stream into words and writes
//   them from word 0 upward. While the load runs, the core is held in reset
//   through core_rstn and fetches return NOP. Outside a load, fetches read
//   the memory with one cycle of latency.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset (deassertion synchronized
//                   outside this block)
//   ins_a      in   [15:0] fetch byte address; bits [1:0] and [15:AW+2]
//                   are ignored
//   ins_e      in   fetch enable
//   ins        out  [31:0] registered fetch data
//   ld_start   in   one-cycle pulse that starts a load (honoured in IDLE only)
//   ld_nwords  in   [AW:0] words to load, sampled with ld_start
//   ld_vld     in   byte-stream valid
//   ld_byte    in   [7:0] byte-stream data
//   ld_rdy     out  byte-stream ready, high only in LOAD
//   ld_done    out  one-cycle pulse in the DONE state
//   core_rstn  out  low while a load is in progress
//   dbg_state  out  [1:0] FSM state: 0 IDLE, 1 LOAD, 2 DONE
//
// Byte-stream handshake: a byte transfers on a rising edge where ld_vld and
// ld_rdy are both high. ld_rdy depends only on the FSM state, never on
// ld_vld; the source may hold ld_vld low for any number of cycles, and the
// load waits indefinitely.

module u_imem #(
    parameter int          AW  = 14,
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [15:0]   ins_a,
    input  logic          ins_e,
    output logic [31:0]   ins,
    input  logic          ld_start,
    input  logic [AW:0]   ld_nwords,
    input  logic          ld_vld,
    input  logic [7:0]    ld_byte,
    output logic          ld_rdy,
    output logic          ld_done,
    output logic          core_rstn,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]    byte_cnt;
    logic [AW:0]   wptr;
    logic [AW:0]   remain;
    logic [31:0]   asm_r;

    logic [31:0]   mem [0:(2**AW)-1];

    logic          xfer;
    logic          word_we;
    logic [31:0]   word_wdata;
    logic          last_word;
    logic          unused_bits;

    // ld_rdy is itself a function of state, so a transfer can only happen
    // in LOAD.
    assign xfer       = ld_vld && ld_rdy;
    assign word_we    = xfer && (byte_cnt == 2'd3);
    assign word_wdata = {ld_byte, asm_r[23:0]};
    assign last_word  = (remain == (AW+1)'(1));

    // The top byte lane of the assembly register is never read back (the
    // fourth byte goes straight into the memory write), wptr[AW] only exists
    // to keep the pointer as wide as the count, and the low / high address
    // bits are ignored on purpose.
    assign unused_bits = ^{ins_a, wptr[AW], asm_r[31:24]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ld_start) begin
                    state_nxt = (ld_nwords != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                // Leave LOAD on the edge that writes the final word.
                if (word_we && last_word) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from state only)
    // ------------------------------------------------------------------
    always_comb begin
        ld_rdy    = 1'b0;
        ld_done   = 1'b0;
        core_rstn = 1'b1;
        dbg_state = state;
        case (state)
            S_LOAD: begin
                ld_rdy    = 1'b1;
                core_rstn = 1'b0;
            end
            S_DONE: begin
                ld_done   = 1'b1;
            end
            default: begin
                ld_rdy    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load datapath: byte counter, word pointer, remaining count, assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
            wptr     <= '0;
            remain   <= '0;
            asm_r    <= '0;
        end else if ((state == S_IDLE) && ld_start) begin
            byte_cnt <= '0;
            wptr     <= '0;
            remain   <= ld_nwords;
        end else if (xfer) begin
            asm_r[{byte_cnt, 3'b000} +: 8] <= ld_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
                wptr   <= wptr + (AW+1)'(1);
                remain <= remain - (AW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array: no reset, so a load leaves untouched words as they were
    // and a reset mid-load keeps the words already written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (word_we) begin
            mem[wptr[AW-1:0]] <= word_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fetch port. Writes only happen in LOAD, and fetches in LOAD return
    // NOP, so a read never races a write to the same word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ins <= '0;
        end else if (ins_e) begin
            if (state == S_LOAD) begin
                ins <= NOP;
            end else begin
                ins <= mem[ins_a[AW+1:2]];
            end
        end
    end

endmodule

// File: tb/tb_u_imem.sv
// tb_u_imem -- directed self-checking bench for u_imem (AW = 14).
// Fetch expectations go through a scoreboard queue: pushed when the fetch is
// driven, popped when the registered data appears one cycle later.

module tb_u_imem;

    localparam int          AW     = 14;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_LOAD = 2'd1;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic          clk;
    logic          rstn;
    logic [15:0]   ins_a;
    logic          ins_e;
    logic [31:0]   ins;
    logic          ld_start;
    logic [AW:0]   ld_nwords;
    logic          ld_vld;
    logic [7:0]    ld_byte;
    logic          ld_rdy;
    logic          ld_done;
    logic          core_rstn;
    logic [1:0]    dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    u_imem #(.AW(AW), .NOP(NOP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ins_a     (ins_a),
        .ins_e     (ins_e),
        .ins       (ins),
        .ld_start  (ld_start),
        .ld_nwords (ld_nwords),
        .ld_vld    (ld_vld),
        .ld_byte   (ld_byte),
        .ld_rdy    (ld_rdy),
        .ld_done   (ld_done),
        .core_rstn (core_rstn),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    int          total;
    int          bad;

    // Stimulus tables used by run_load.
    logic [7:0]  bq[$];
    bit          vq[$];

    // Results of the most recent run_load.
    int          n_rdy;
    int          n_crst;
    int          n_xfer;
    int          last_xfer_cyc;
    int          done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic fetch(input logic [15:0] addr, input logic [31:0] expv);
        ins_e = 1'b1;
        ins_a = addr;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        ins_e = 1'b0;
        @(negedge clk);
        check("fetch", ins, exp_q.pop_front());
    endtask

    // Starts a load of nw words, then streams bq gated by the ld_vld
    // pattern vq (1 once the pattern runs out) until ld_done is seen.
    // A fetch of address fa is held enabled throughout. restart_cyc >= 0
    // pulses ld_start (with a different count) in that cycle of the load.
    task automatic run_load(input int nw, input logic [15:0] fa, input int restart_cyc);
        int cyc;
        ld_nwords = (AW+1)'(nw);
        ld_start  = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        ins_e    = 1'b1;
        ins_a    = fa;
        n_rdy = 0; n_crst = 0; n_xfer = 0;
        last_xfer_cyc = -1; done_cyc = -1;
        cyc = 0;
        while (done_cyc < 0 && cyc < 200) begin
            ld_vld  = (cyc < vq.size()) ? vq[cyc] : 1'b1;
            ld_byte = (n_xfer < bq.size()) ? bq[n_xfer] : 8'h00;
            if (cyc == restart_cyc) begin
                ld_start  = 1'b1;
                ld_nwords = (AW+1)'(5);
            end else begin
                ld_start  = 1'b0;
            end
            @(negedge clk);
            if (ld_rdy) n_rdy++;
            if (!core_rstn) n_crst++;
            if (dbg_state == S_LOAD && cyc >= 1) check("nop_in_load", ins, NOP);
            if (ld_done) begin
                done_cyc = cyc;
                if (nw > 0) check("nop_in_done", ins, NOP);
            end
            if (ld_rdy && ld_vld) begin
                n_xfer++;
                last_xfer_cyc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        ld_vld   = 1'b0;
        ld_start = 1'b0;
        if (done_cyc < 0) check("load_timeout", 32'(cyc), 32'(-1));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        rstn = 1'b0; ins_a = '0; ins_e = 1'b0; ld_start = 1'b0;
        ld_nwords = '0; ld_vld = 1'b0; ld_byte = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_ins", ins, 32'h0);
        check("rst_rdy", 32'(ld_rdy), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_core_rstn", 32'(core_rstn), 32'd1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-word load, with an ignored ld_start in the middle and a
        // fetch of word 1 held through the load.
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
        vq = '{};
        run_load(2, 16'h0004, 3);
        check("basic_rdy_cycles", 32'(n_rdy), 32'd8);
        check("basic_core_rstn_cycles", 32'(n_crst), 32'd8);
        check("basic_xfers", 32'(n_xfer), 32'd8);
        check("basic_done_gap", 32'(done_cyc - last_xfer_cyc), 32'd1);
        @(negedge clk);
        check("basic_fetch_after_load", ins, 32'h0010_00B3);
        check("basic_state_idle", 32'(dbg_state), 32'(S_IDLE));

        // Fetches, low-bit alias, hold with ins_e low
        fetch(16'h0004, 32'h0010_00B3);
        fetch(16'h0000, 32'h0000_0013);
        fetch(16'h0007, 32'h0010_00B3);
        ins_a = 16'h0000;
        repeat (2) @(negedge clk);
        check("hold_ins_e0", ins, 32'h0010_00B3);
        fetch(16'h0003, 32'h0000_0013);

        // Stalled one-word load; fetch of word 0 held through the load
        bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        vq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_load(1, 16'h0000, -1);
        check("stall_xfers", 32'(n_xfer), 32'd4);
        check("stall_rdy_cycles", 32'(n_rdy), 32'd7);
        check("stall_done_gap", 32'(done_cyc - last_xfer_cyc), 32'd1);
        check("stall_last_xfer_cyc", 32'(last_xfer_cyc), 32'd6);
        @(negedge clk);
        check("stall_fetch_after_load", ins, 32'hDEAD_BEEF);
        fetch(16'h0000, 32'hDEAD_BEEF);
        fetch(16'h0004, 32'h0010_00B3);

        // Zero-length load
        bq = '{};
        vq = '{};
        run_load(0, 16'h0004, -1);
        check("zero_done_cyc", 32'(done_cyc), 32'd0);
        check("zero_rdy_cycles", 32'(n_rdy), 32'd0);
        check("zero_core_rstn_cycles", 32'(n_crst), 32'd0);
        fetch(16'h0000, 32'hDEAD_BEEF);

        // Reset after 6 of 8 bytes
        ld_nwords = (AW+1)'(2);
        ld_start  = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) begin
            ld_vld  = 1'b1;
            ld_byte = bq[i];
            @(posedge clk);
            #1;
        end
        ld_vld = 1'b0;
        rstn   = 1'b0;
        #2;
        check("abort_state", 32'(dbg_state), 32'(S_IDLE));
        check("abort_rdy", 32'(ld_rdy), 32'd0);
        check("abort_core_rstn", 32'(core_rstn), 32'd1);
        check("abort_ins", ins, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        fetch(16'h0000, 32'h4433_2211);
        fetch(16'h0004, 32'h0010_00B3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
